// File: rtl/pe_pkg.sv
// Shared definitions for the PE pass scheduler: config field decode, FSM
// state encodings and the per-pass word count helpers.
package pe_pkg;

  localparam int PE_CFG_W   = 13;
  localparam int DW_BIT     = 12;
  localparam int RS_LSB     = 10;
  localparam int P_LSB      = 7;
  localparam int COLS_LSB   = 2;
  localparam int Q_LSB      = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LD_FILT, S_LD_IFMAP, S_LD_IPSUM, S_ST_OPSUM, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_FETCH, PH_CAP, PH_PRES
  } fetch_phase_t;

  function automatic logic [2:0] rs_of(input logic [PE_CFG_W-1:0] c);
    return {1'b0, c[RS_LSB+:2]} + 3'd1;
  endfunction

  function automatic logic [2:0] p_of(input logic [PE_CFG_W-1:0] c);
    return {1'b0, c[P_LSB+:2]} + 3'd1;
  endfunction

  function automatic logic [2:0] q_of(input logic [PE_CFG_W-1:0] c);
    return {1'b0, c[Q_LSB+:2]} + 3'd1;
  endfunction

  function automatic logic [5:0] cols_of(input logic [PE_CFG_W-1:0] c);
    return {1'b0, c[COLS_LSB+:5]} + 6'd1;
  endfunction

  // Psum words per column: Q for depthwise layers, P otherwise.
  function automatic logic [2:0] n_psum(input logic [PE_CFG_W-1:0] c);
    return c[DW_BIT] ? q_of(c) : p_of(c);
  endfunction

  function automatic logic [4:0] word_count_filter(input logic [PE_CFG_W-1:0] c);
    return {2'b00, p_of(c)} * {2'b00, rs_of(c)};
  endfunction

endpackage

// File: rtl/glb_fetch_unit.sv
// One-word GLB fetch: issues a read, captures the data one cycle later and
// presents it on a valid/ready output until it is taken.
module glb_fetch_unit
  import pe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              fire
);

  // Handshake: a word transfers in any cycle where valid && ready; once valid
  // rises, valid and data hold until that cycle.
  fetch_phase_t phase;
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_FETCH;
      hold  <= '0;
    end else begin
      case (phase)
        PH_FETCH: if (req) phase <= PH_CAP;
        PH_CAP: begin
          hold  <= rdata;
          phase <= PH_PRES;
        end
        PH_PRES:  if (ready) phase <= PH_FETCH;
        default:  phase <= PH_FETCH;
      endcase
    end
  end

  assign ren   = req && (phase == PH_FETCH);
  assign valid = (phase == PH_PRES);
  assign data  = hold;
  assign fire  = valid && ready;

endmodule

// File: rtl/pe_pass_scheduler.sv
// Walks one PE through a full pass: config strobe, filter/ifmap/ipsum loads
// from the GLB and opsum write-back, one column at a time.
module pe_pass_scheduler
  import pe_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CFG_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] ipsum_base,
  input  logic [ADDR_W-1:0] opsum_base,
  output logic              busy,
  output logic              done,
  output logic              glb_ren,
  output logic [ADDR_W-1:0] glb_raddr,
  input  logic [DATA_W-1:0] glb_rdata,
  output logic              glb_wen,
  output logic [ADDR_W-1:0] glb_waddr,
  output logic [DATA_W-1:0] glb_wdata,
  output logic              PE_en,
  output logic [CFG_W-1:0]  pe_config,
  output logic [DATA_W-1:0] pe_ifmap,
  output logic [DATA_W-1:0] pe_filter,
  output logic [DATA_W-1:0] pe_ipsum,
  output logic              pe_ifmap_valid,
  output logic              pe_filter_valid,
  output logic              pe_ipsum_valid,
  input  logic              pe_ifmap_ready,
  input  logic              pe_filter_ready,
  input  logic              pe_ipsum_ready,
  input  logic [DATA_W-1:0] pe_opsum,
  input  logic              pe_opsum_valid,
  output logic              pe_opsum_ready
);

  state_t state;
  logic [CFG_W-1:0]  cfg_q;
  logic [ADDR_W-1:0] filt_q, ifmap_q, ipsum_q, opsum_q;
  logic [4:0] k;
  logic [5:0] m;
  logic [4:0] col;
  logic [2:0] j;
  logic [1:0] icnt;

  logic [2:0] rs, n;
  logic [5:0] cols;
  logic [4:0] nfilt;
  logic [ADDR_W-1:0] psum_off;

  logic req, fire, hold_valid, chan_ready;
  logic [DATA_W-1:0] hold_data;

  assign rs       = rs_of(cfg_q);
  assign n        = n_psum(cfg_q);
  assign cols     = cols_of(cfg_q);
  assign nfilt    = word_count_filter(cfg_q);
  assign psum_off = ADDR_W'(col) * ADDR_W'(n) + ADDR_W'(j);

  always_comb begin
    req        = 1'b0;
    chan_ready = 1'b0;
    glb_raddr  = '0;
    case (state)
      S_LD_FILT: begin
        req = 1'b1; chan_ready = pe_filter_ready; glb_raddr = filt_q + ADDR_W'(k);
      end
      S_LD_IFMAP: begin
        req = 1'b1; chan_ready = pe_ifmap_ready; glb_raddr = ifmap_q + ADDR_W'(m);
      end
      S_LD_IPSUM: begin
        req = 1'b1; chan_ready = pe_ipsum_ready; glb_raddr = ipsum_q + psum_off;
      end
      default: ;
    endcase
  end

  glb_fetch_unit #(.DATA_W(DATA_W)) u_fetch (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ren   (glb_ren),
    .rdata (glb_rdata),
    .valid (hold_valid),
    .data  (hold_data),
    .ready (chan_ready),
    .fire  (fire)
  );

  // One hold register feeds all three PE inputs; only the active channel's valid rises.
  assign pe_filter       = hold_data;
  assign pe_ifmap        = hold_data;
  assign pe_ipsum        = hold_data;
  assign pe_filter_valid = hold_valid && (state == S_LD_FILT);
  assign pe_ifmap_valid  = hold_valid && (state == S_LD_IFMAP);
  assign pe_ipsum_valid  = hold_valid && (state == S_LD_IPSUM);

  assign pe_opsum_ready = (state == S_ST_OPSUM);
  assign glb_wen        = pe_opsum_valid && pe_opsum_ready;
  assign glb_waddr      = pe_opsum_ready ? opsum_q + psum_off : '0;
  assign glb_wdata      = pe_opsum_ready ? pe_opsum : '0;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign PE_en     = (state == S_CFG);
  assign pe_config = cfg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cfg_q   <= '0;
      filt_q  <= '0;
      ifmap_q <= '0;
      ipsum_q <= '0;
      opsum_q <= '0;
      k       <= '0;
      m       <= '0;
      col     <= '0;
      j       <= '0;
      icnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cfg_q   <= cfg;
          filt_q  <= filt_base;
          ifmap_q <= ifmap_base;
          ipsum_q <= ipsum_base;
          opsum_q <= opsum_base;
          k       <= '0;
          m       <= '0;
          col     <= '0;
          j       <= '0;
          icnt    <= '0;
          state   <= S_CFG;
        end
        S_CFG: state <= S_LD_FILT;
        S_LD_FILT: if (fire) begin
          if (k == nfilt - 5'd1) begin
            icnt  <= '0;
            state <= S_LD_IFMAP;
          end else k <= k + 5'd1;
        end
        // Column 0 primes RS ifmap words; later columns slide the window by one.
        S_LD_IFMAP: if (fire) begin
          m <= m + 6'd1;
          if (col != 5'd0 || {1'b0, icnt} == rs - 3'd1) begin
            j     <= '0;
            state <= S_LD_IPSUM;
          end else icnt <= icnt + 2'd1;
        end
        S_LD_IPSUM: if (fire) begin
          if (j == n - 3'd1) begin
            j     <= '0;
            state <= S_ST_OPSUM;
          end else j <= j + 3'd1;
        end
        S_ST_OPSUM: if (glb_wen) begin
          if (j == n - 3'd1) begin
            j <= '0;
            if ({1'b0, col} == cols - 6'd1) state <= S_DONE;
            else begin
              col   <= col + 5'd1;
              state <= S_LD_IFMAP;
            end
          end else j <= j + 3'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_pass_scheduler.sv
// Directed bench for pe_pass_scheduler with a 1-cycle GLB model and a PE
// model whose readys and opsum stream are driven by the scenario tasks.
module tb_pe_pass_scheduler;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [CW-1:0] cfg = '0;
  logic [AW-1:0] filt_base = '0, ifmap_base = '0, ipsum_base = '0, opsum_base = '0;
  logic busy, done, glb_ren, glb_wen, PE_en;
  logic [AW-1:0] glb_raddr, glb_waddr;
  logic [DW-1:0] glb_rdata = '0;
  logic [DW-1:0] glb_wdata, pe_ifmap, pe_filter, pe_ipsum, pe_opsum;
  logic [CW-1:0] pe_config;
  logic pe_ifmap_valid, pe_filter_valid, pe_ipsum_valid, pe_opsum_ready;
  logic pe_ifmap_ready = 1'b1, pe_filter_ready = 1'b1, pe_ipsum_ready = 1'b1;
  logic pe_opsum_valid = 1'b1;

  pe_pass_scheduler #(.ADDR_W(AW), .DATA_W(DW), .CFG_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .filt_base(filt_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done),
    .glb_ren(glb_ren), .glb_raddr(glb_raddr), .glb_rdata(glb_rdata),
    .glb_wen(glb_wen), .glb_waddr(glb_waddr), .glb_wdata(glb_wdata),
    .PE_en(PE_en), .pe_config(pe_config),
    .pe_ifmap(pe_ifmap), .pe_filter(pe_filter), .pe_ipsum(pe_ipsum),
    .pe_ifmap_valid(pe_ifmap_valid), .pe_filter_valid(pe_filter_valid),
    .pe_ipsum_valid(pe_ipsum_valid),
    .pe_ifmap_ready(pe_ifmap_ready), .pe_filter_ready(pe_filter_ready),
    .pe_ipsum_ready(pe_ipsum_ready),
    .pe_opsum(pe_opsum), .pe_opsum_valid(pe_opsum_valid),
    .pe_opsum_ready(pe_opsum_ready)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  function automatic logic [DW-1:0] gmem(input logic [AW-1:0] a);
    return 32'hA500_0000 | {20'h0, a};
  endfunction

  // GLB: data valid exactly one cycle after ren, garbage otherwise.
  always @(posedge clk) glb_rdata <= glb_ren ? gmem(glb_raddr) : 32'hDEAD_BEEF;

  int unsigned op_cnt = 0;
  always @(posedge clk) if (glb_wen) op_cnt <= op_cnt + 1;
  assign pe_opsum = 32'hC0DE_0000 + op_cnt;

  logic [173:0] all_out;
  assign all_out = {busy, done, glb_ren, glb_raddr, glb_wen, glb_waddr, glb_wdata,
                    PE_en, pe_config, pe_ifmap, pe_filter, pe_ipsum,
                    pe_ifmap_valid, pe_filter_valid, pe_ipsum_valid, pe_opsum_ready};

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [DW-1:0] fd_q[$];
  logic [DW-1:0] id_q[$];
  int done_n, en_n, filt_n, ips_phases, last_ch;
  logic [CW-1:0] cfg_seen;

  always @(negedge clk) if (!rst) begin
    if (glb_ren) rd_q.push_back(glb_raddr);
    if (glb_wen) begin wa_q.push_back(glb_waddr); wd_q.push_back(glb_wdata); end
    if (done) done_n++;
    if (PE_en) begin en_n++; cfg_seen = pe_config; end
    if (pe_filter_valid && pe_filter_ready) begin filt_n++; fd_q.push_back(pe_filter); last_ch = 0; end
    if (pe_ifmap_valid && pe_ifmap_ready) begin id_q.push_back(pe_ifmap); last_ch = 1; end
    if (pe_ipsum_valid && pe_ipsum_ready) begin
      if (last_ch != 2) ips_phases++;
      last_ch = 2;
    end
  end

  // driver tasks
  task automatic clear_logs();
    exp_q.delete(); exp_wa_q.delete(); rd_q.delete(); wa_q.delete();
    wd_q.delete(); fd_q.delete(); id_q.delete();
    done_n = 0; en_n = 0; filt_n = 0; ips_phases = 0; last_ch = 3; cfg_seen = '0;
  endtask

  task automatic kick(input logic [CW-1:0] c, input logic [AW-1:0] fb, ib, pb, ob);
    @(posedge clk); #1;
    clear_logs();
    cfg = c; filt_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg = '0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
    checks++;
    if (glb_wen !== 1'b0) begin failures++; $display("FAIL idle_wen got=%b exp=0", glb_wen); end
  endtask

  // Runs one pass and compares every GLB read, write and PE transfer.
  task automatic test_pass(input string name, input logic [CW-1:0] c,
                           input logic [AW-1:0] fb, ib, pb, ob, input bit poke);
    int p, rs, cols, n, m, cnt;
    int unsigned op_base;
    bit ok;
    p = int'(c[8:7]) + 1; rs = int'(c[11:10]) + 1; cols = int'(c[6:2]) + 1;
    n = c[12] ? int'(c[1:0]) + 1 : p;
    kick(c, fb, ib, pb, ob);
    op_base = op_cnt;
    for (int k = 0; k < p * rs; k++) exp_q.push_back(AW'(fb + k));
    m = 0;
    for (int cl = 0; cl < cols; cl++) begin
      cnt = (cl == 0) ? rs : 1;
      for (int i = 0; i < cnt; i++) begin exp_q.push_back(AW'(ib + m)); m++; end
      for (int jj = 0; jj < n; jj++) exp_q.push_back(AW'(pb + cl * n + jj));
      for (int jj = 0; jj < n; jj++) exp_wa_q.push_back(AW'(ob + cl * n + jj));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || PE_en !== 1'b1) begin
      failures++; $display("FAIL %s_cfg_cycle busy=%b PE_en=%b exp=1,1", name, busy, PE_en);
    end
    if (poke) begin
      repeat (8) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_done_timeout got=0 exp=1", name); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%b exp=0", name, busy); end
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_after got=%b exp=0", name, busy); end
    checks++;
    if (rd_q.size() != exp_q.size()) begin
      failures++; $display("FAIL %s_read_count got=%0d exp=%0d", name, rd_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL %s_raddr[%0d] got=%h exp=%h", name, i, rd_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wa_q.size() != exp_wa_q.size()) begin
      failures++; $display("FAIL %s_write_count got=%0d exp=%0d", name, wa_q.size(), exp_wa_q.size());
    end
    for (int i = 0; i < exp_wa_q.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== exp_wa_q[i] || wd_q[i] !== 32'hC0DE_0000 + op_base + i) begin
        failures++;
        $display("FAIL %s_write[%0d] got=%h/%h exp=%h/%h", name, i, wa_q[i], wd_q[i],
                 exp_wa_q[i], 32'hC0DE_0000 + op_base + i);
      end
    end
    checks++;
    if (fd_q.size() != p * rs) begin
      failures++; $display("FAIL %s_filter_count got=%0d exp=%0d", name, fd_q.size(), p * rs);
    end
    for (int i = 0; i < fd_q.size(); i++) begin
      checks++;
      if (fd_q[i] !== gmem(AW'(fb + i))) begin
        failures++; $display("FAIL %s_filter_data[%0d] got=%h exp=%h", name, i, fd_q[i], gmem(AW'(fb + i)));
      end
    end
    for (int i = 0; i < id_q.size(); i++) begin
      checks++;
      if (id_q[i] !== gmem(AW'(ib + i))) begin
        failures++; $display("FAIL %s_ifmap_data[%0d] got=%h exp=%h", name, i, id_q[i], gmem(AW'(ib + i)));
      end
    end
    checks++;
    if (done_n != 1 || en_n != 1 || cfg_seen !== c) begin
      failures++;
      $display("FAIL %s_pulses done=%0d en=%0d cfg=%h exp=1,1,%h", name, done_n, en_n, cfg_seen, c);
    end
    checks++;
    if (ips_phases != cols) begin
      failures++; $display("FAIL %s_ipsum_phases got=%0d exp=%0d", name, ips_phases, cols);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d0;
    bit seen, ok;
    pe_filter_ready = 1'b0;
    kick(13'h0882, 12'h100, 12'h200, 12'h300, 12'h400);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pe_filter_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL stall_valid_timeout got=0 exp=1"); end
    d0 = pe_filter;
    checks++;
    if (d0 !== gmem(12'h100)) begin failures++; $display("FAIL stall_first_data got=%h exp=%h", d0, gmem(12'h100)); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (pe_filter_valid !== 1'b1 || pe_filter !== gmem(12'h100)) begin
        failures++;
        $display("FAIL stall_hold[%0d] valid=%b data=%h exp=1,%h", i, pe_filter_valid, pe_filter, gmem(12'h100));
      end
    end
    @(posedge clk); #1 pe_filter_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (filt_n != 1 || pe_filter_valid !== 1'b0) begin
      failures++; $display("FAIL stall_one_transfer got=%0d valid=%b exp=1,0", filt_n, pe_filter_valid);
    end
    wait_done(ok);
    checks++;
    if (!ok || filt_n != 6) begin failures++; $display("FAIL stall_finish done=%b filt=%0d exp=1,6", ok, filt_n); end
  endtask

  task automatic test_mid_reset();
    bit seen;
    kick(13'h0882, 12'h100, 12'h200, 12'h300, 12'h400);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = pe_ipsum_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midrst_ipsum_timeout got=0 exp=1"); end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL midrst_async got=%h exp=0", all_out); end
    @(negedge clk);
    checks++;
    if (all_out !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_next_cycle got=%h busy=%b exp=0,0", all_out, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    test_pass("after_rst", 13'h0882, 12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass("single_col", 13'h0882, 12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    test_pass("multi_col",  13'h088A, 12'h110, 12'h000, 12'h320, 12'h480, 1'b0);
    test_pass("depthwise",  13'h1007, 12'h050, 12'h060, 12'h070, 12'h080, 1'b0);
    test_stall();
    test_mid_reset();
    test_pass("busy_wrap",  13'h1003, 12'h010, 12'h020, 12'hFFE, 12'h7F0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
